// File: rtl/wb_sram_slave.sv
// Wishbone classic slave in front of a synchronous single-port word RAM.
// One request is latched in IDLE, optionally delayed by WAIT_STATES idle
// cycles, issued to the RAM for exactly one ACCESS cycle and then
// acknowledged. Out-of-range addresses get a single-cycle error instead.
// Dropping cyc at any point after the latch abandons the transfer silently.
module wb_sram_slave #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            MEM_AW      = 14,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            WAIT_STATES = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     s_wbd_adr_i,
  input  logic [DATA_WIDTH-1:0]     s_wbd_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   s_wbd_sel_i,
  input  logic                      s_wbd_we_i,
  input  logic                      s_wbd_cyc_i,
  input  logic                      s_wbd_stb_i,
  output logic [DATA_WIDTH-1:0]     s_wbd_dat_o,
  output logic                      s_wbd_ack_o,
  output logic                      s_wbd_err_o,
  output logic [MEM_AW-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic                      mem_re_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned SEL_W   = DATA_WIDTH / 8;
  // Wait counter is 4 bits wide, so WAIT_STATES is meaningful up to 15.
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ACK,
    S_ERR
  } state_t;

  state_t                  state_q,    state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [MEM_AW-1:0]       addr_q,     addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
  logic [SEL_W-1:0]        sel_q,      sel_d;
  logic                    we_q,       we_d;

  logic                    req;
  logic                    hit;

  // An address hits the RAM when it is at or above the base and its word
  // offset fits in MEM_AW bits; the subtraction wraps at ADDR_WIDTH.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] adr);
    logic [ADDR_WIDTH-1:0] off;
    off = adr - BASE_ADDR;
    return (adr >= BASE_ADDR) && ((off >> (MEM_AW + 2)) == '0);
  endfunction

  // Word index inside the RAM; the two byte-offset bits are dropped.
  function automatic logic [MEM_AW-1:0] word_index(input logic [ADDR_WIDTH-1:0] adr);
    logic [ADDR_WIDTH-1:0] off;
    off = adr - BASE_ADDR;
    return off[MEM_AW+1:2];
  endfunction

  assign req = s_wbd_cyc_i & s_wbd_stb_i;
  assign hit = addr_in_range(s_wbd_adr_i);

  // State, wait counter and latched request registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
    end
  end

  // Next-state logic; the request is captured only when IDLE sees cyc&stb.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    we_d       = we_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = word_index(s_wbd_adr_i);
          wdata_d = s_wbd_dat_i;
          sel_d   = s_wbd_sel_i;
          we_d    = s_wbd_we_i;
          if (!hit) begin
            state_d = S_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = WS_INIT;
          end
        end
      end

      S_WAIT: begin
        if (!s_wbd_cyc_i) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q <= 4'd1) begin
          state_d    = S_ACCESS;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      S_ACCESS: begin
        state_d = s_wbd_cyc_i ? S_ACK : S_IDLE;
      end

      // Both response states always fall back to IDLE, which guarantees
      // at least one IDLE cycle between consecutive transfers.
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and RAM outputs decoded from the state; everything is gated by cyc
  // so an aborted cycle never produces a response or a RAM pulse.
  always_comb begin
    s_wbd_dat_o = '0;
    s_wbd_ack_o = 1'b0;
    s_wbd_err_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    mem_re_o    = 1'b0;

    if (s_wbd_cyc_i) begin
      unique case (state_q)
        S_ACCESS: begin
          mem_addr_o = addr_q;
          if (we_q) begin
            // sel=0 yields an all-zero byte enable: acknowledged, no write.
            mem_be_o    = sel_q;
            mem_wdata_o = wdata_q;
          end else begin
            mem_re_o = 1'b1;
          end
        end

        S_ACK: begin
          s_wbd_ack_o = 1'b1;
          // RAM data arrives one cycle after mem_re_o, i.e. in this cycle.
          if (!we_q) begin
            s_wbd_dat_o = mem_rdata_i;
          end
        end

        S_ERR: begin
          s_wbd_err_o = 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: two instances (0 and 3 wait states) share one
// bus driver, each with its own behavioural RAM. A word-array model of the
// memory predicts read data, responses and latencies.
module tb_wb_sram_slave;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          MAW  = 6;
  localparam int          NW   = 1 << MAW;
  localparam int          NI   = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;

  logic [31:0]    dat_o  [NI];
  logic           ack    [NI];
  logic           err    [NI];
  logic [MAW-1:0] maddr  [NI];
  logic [31:0]    mwdata [NI];
  logic [3:0]     mbe    [NI];
  logic           mre    [NI];

  int checks = 0;
  int errors = 0;

  logic [31:0] model [NW];

  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    logic [31:0] ram [NW] = '{default: '0};
    logic [31:0] rdata = '0;

    wb_sram_slave #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_AW     (MAW),
      .BASE_ADDR  (BASE),
      .WAIT_STATES((k == 0) ? 0 : 3)
    ) u_dut (
      .clk_i      (clk),
      .rst_n      (rst_n),
      .s_wbd_adr_i(adr),
      .s_wbd_dat_i(wdat),
      .s_wbd_sel_i(sel),
      .s_wbd_we_i (we),
      .s_wbd_cyc_i(cyc),
      .s_wbd_stb_i(stb),
      .s_wbd_dat_o(dat_o[k]),
      .s_wbd_ack_o(ack[k]),
      .s_wbd_err_o(err[k]),
      .mem_addr_o (maddr[k]),
      .mem_wdata_o(mwdata[k]),
      .mem_be_o   (mbe[k]),
      .mem_re_o   (mre[k]),
      .mem_rdata_i(rdata)
    );

    // Synchronous RAM: read data valid the cycle after mem_re_o.
    always @(posedge clk) begin
      if (mre[k]) rdata <= ram[maddr[k]];
      for (int b = 0; b < 4; b++)
        if (mbe[k][b]) ram[maddr[k]][8*b +: 8] <= mwdata[k][8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(NW * 4));
  endfunction

  task automatic chk_zero(input string tag);
    for (int k = 0; k < NI; k++)
      check($sformatf("%s/i%0d outputs", tag, k),
            32'({ack[k], err[k], mre[k], |mbe[k], |maddr[k], |mwdata[k], |dat_o[k]}), 32'd0);
  endtask

  // One transfer on both instances; compares every observation to the model.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag,
                      output logic [31:0] rd0, output logic err0);
    logic        inr, exp_acc;
    int          word;
    logic [31:0] exp_dat;
    int          ack_cnt [NI], err_cnt [NI], rsp_n [NI], acc_cnt [NI], acc_n [NI];
    logic [31:0] rd [NI];
    logic [MAW-1:0] acc_addr [NI];
    logic [3:0]  acc_be [NI];
    logic        acc_re [NI];

    inr     = in_range(a);
    word    = inr ? int'((a - BASE) >> 2) : 0;
    exp_dat = (inr && !w) ? model[word] : 32'd0;
    exp_acc = inr && (!w || s != 4'd0);
    if (inr && w)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[word][8*b +: 8] = d[8*b +: 8];

    for (int k = 0; k < NI; k++) begin
      ack_cnt[k] = 0; err_cnt[k] = 0; rsp_n[k] = 0; acc_cnt[k] = 0; acc_n[k] = 0;
      rd[k] = '0; acc_addr[k] = '0; acc_be[k] = '0; acc_re[k] = 1'b0;
    end

    @(posedge clk); #1;
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 1) stb = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (ack[k]) begin ack_cnt[k]++; rsp_n[k] = n; rd[k] = dat_o[k]; end
        if (err[k]) begin err_cnt[k]++; rsp_n[k] = n; rd[k] = dat_o[k]; end
        if (mre[k] || mbe[k] != 4'd0) begin
          acc_cnt[k]++; acc_n[k] = n;
          acc_addr[k] = maddr[k]; acc_be[k] = mbe[k]; acc_re[k] = mre[k];
        end
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; we = 1'b0;

    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s/i%0d ack_count", tag, k), 32'(ack_cnt[k]), inr ? 32'd1 : 32'd0);
      check($sformatf("%s/i%0d err_count", tag, k), 32'(err_cnt[k]), inr ? 32'd0 : 32'd1);
      check($sformatf("%s/i%0d latency", tag, k), 32'(rsp_n[k]),
            inr ? 32'(ws_of(k) + 2) : 32'd1);
      check($sformatf("%s/i%0d dat_o", tag, k), rd[k], exp_dat);
      check($sformatf("%s/i%0d mem_pulses", tag, k), 32'(acc_cnt[k]), 32'(exp_acc));
      if (exp_acc) begin
        check($sformatf("%s/i%0d mem_cycle", tag, k), 32'(acc_n[k]), 32'(ws_of(k) + 1));
        check($sformatf("%s/i%0d mem_addr", tag, k), 32'(acc_addr[k]), 32'(word));
        if (w) check($sformatf("%s/i%0d mem_be", tag, k), 32'(acc_be[k]), 32'(s));
        else   check($sformatf("%s/i%0d mem_re", tag, k), 32'(acc_re[k]), 32'd1);
      end
    end
    rd0  = rd[0];
    err0 = (err_cnt[0] != 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        tbl [14];
    logic [31:0] rd;
    logic        e;
    int          ack_seen [NI];
    int          acc_seen;

    for (int i = 0; i < NW; i++) model[i] = '0;

    tbl[0]  = '{1'b1, BASE + 32'h10,  32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, BASE + 32'h10,  32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, BASE + 32'h20,  32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, BASE + 32'h20,  32'h1122_3344, 4'h5, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, BASE + 32'h20,  32'h0,         4'hF, 1'b0, 32'hFF22_FF44};
    tbl[5]  = '{1'b0, BASE + 32'h100, 32'h0,         4'hF, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, BASE - 32'h4,   32'h1234_5678, 4'hF, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, BASE + 32'h10,  32'h0,         4'h0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, BASE + 32'h13,  32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    tbl[9]  = '{1'b1, BASE + 32'hFC,  32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    tbl[10] = '{1'b0, BASE + 32'hFC,  32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
    tbl[11] = '{1'b1, BASE + 32'h10,  32'h0000_AB00, 4'h2, 1'b0, 32'h0};
    tbl[12] = '{1'b0, BASE + 32'h10,  32'h0,         4'hF, 1'b0, 32'hDEAD_ABEF};
    tbl[13] = '{1'b0, 32'hFFFF_FFFC,  32'h0,         4'hF, 1'b1, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, $sformatf("tbl%0d", i), rd, e);
      check($sformatf("tbl%0d err", i), 32'(e), 32'(tbl[i].exp_err));
      if (!tbl[i].we && !tbl[i].exp_err)
        check($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
    end

    // Abort: cyc dropped one cycle after the latch
    @(posedge clk); #1;
    adr = BASE + 32'h20; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    ack_seen[0] = 0; ack_seen[1] = 0; acc_seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (ack[k] || err[k]) ack_seen[k]++;
      if (mre[1] || mbe[1] != 4'd0) acc_seen++;
    end
    check("abort/i0 responses", 32'(ack_seen[0]), 32'd0);
    check("abort/i1 responses", 32'(ack_seen[1]), 32'd0);
    check("abort/i1 mem_pulses", 32'(acc_seen), 32'd0);
    xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, "post_abort", rd, e);
    check("post_abort rdata", rd, 32'hFF22_FF44);

    // Back-to-back reads with stb held high
    xfer(1'b1, BASE + 32'h30, 32'hA5A5_0F0F, 4'hF, "b2b_fill", rd, e);
    @(posedge clk); #1;
    adr = BASE + 32'h30; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    ack_seen[0] = 0; ack_seen[1] = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++)
        if (ack[k]) begin
          ack_seen[k]++;
          check($sformatf("b2b/i%0d ack_phase@%0d", k, n), 32'(n % (ws_of(k) + 3)),
                32'(ws_of(k) + 2));
          check($sformatf("b2b/i%0d data@%0d", k, n), dat_o[k], 32'hA5A5_0F0F);
        end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    check("b2b/i0 ack_count", 32'(ack_seen[0]), 32'd4);
    check("b2b/i1 ack_count", 32'(ack_seen[1]), 32'd2);

    // Reset while instance 1 waits and instance 0 is accessing
    @(posedge clk); #1;
    adr = BASE + 32'h10; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(posedge clk); #1;
    cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen[0] = 0; ack_seen[1] = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (ack[k] || err[k]) ack_seen[k]++;
    end
    check("midreset/i0 responses", 32'(ack_seen[0]), 32'd0);
    check("midreset/i1 responses", 32'(ack_seen[1]), 32'd0);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, "post_reset", rd, e);
    check("post_reset rdata", rd, 32'hDEAD_ABEF);

    // Randomized transfers against the model
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom() : BASE + 32'($urandom_range(0, NW * 4 - 1));
      xfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
           $sformatf("rnd%0d", i), rd, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
